// File: rtl/dice_race_game_fsm.sv
// Two-player dice-race turn controller: accepts one colour/step result per roll, animates the piece, detects the win.
// Build option DICE_RACE_OVERSHOOT_BOUNCE_EN: overshooting the finish bounces back (default: clamp on finish).
//
// state       | meaning
// IDLE        | after reset, waits for start_game
// WAIT_ROLL   | waits for the current player's roll_req
// WAIT_RESULT | waits for an acceptable colour result
// MOVE        | one cell per STEP_INTERVAL cycles until steps are used up
// CHECK       | active piece on finish cell -> win
// SWITCH      | hand the turn to the other player
// GAME_OVER   | frozen until start_game
module dice_race_game_fsm #(
    parameter int          TRACK_LEN      = 20,
    parameter int          POS_W          = 5,
    parameter int          STEP_INTERVAL  = 12_500_000,
    parameter logic [15:0] MIN_CONFIDENCE = 16'd100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_game,
    input  logic             roll_req,
    input  logic             color_result_ready,
    input  logic [1:0]       movement_steps,
    input  logic [1:0]       detected_color,
    input  logic [15:0]      color_confidence,
    output logic             current_player,
    output logic [POS_W-1:0] p0_pos,
    output logic [POS_W-1:0] p1_pos,
    output logic [1:0]       steps_remaining,
    output logic [1:0]       last_color,
    output logic             step_tick,
    output logic             game_over,
    output logic             winner,
    output logic [2:0]       fsm_state
);

    localparam int               CNT_W  = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] TC     = CNT_W'(STEP_INTERVAL - 1);
    localparam logic [POS_W-1:0] FINISH = POS_W'(TRACK_LEN - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_ROLL   = 3'd1,
        WAIT_RESULT = 3'd2,
        MOVE        = 3'd3,
        CHECK       = 3'd4,
        SWITCH      = 3'd5,
        GAME_OVER   = 3'd6
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             player_d, tick_d, over_d, winner_d;
    logic [POS_W-1:0] p0_d, p1_d, active_pos, next_pos;
    logic [1:0]       steps_d, color_d;
`ifdef DICE_RACE_OVERSHOOT_BOUNCE_EN
    logic             dir, dir_d;
`endif

    assign fsm_state  = state;
    assign active_pos = current_player ? p1_pos : p0_pos;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        player_d = current_player;
        p0_d     = p0_pos;
        p1_d     = p1_pos;
        steps_d  = steps_remaining;
        color_d  = last_color;
        tick_d   = 1'b0;
        over_d   = game_over;
        winner_d = winner;
        next_pos = active_pos;
`ifdef DICE_RACE_OVERSHOOT_BOUNCE_EN
        dir_d    = dir;
`endif
        if (start_game) begin
            state_d  = WAIT_ROLL;
            cnt_d    = '0;
            player_d = 1'b0;
            p0_d     = '0;
            p1_d     = '0;
            steps_d  = 2'd0;
            over_d   = 1'b0;
            winner_d = 1'b0;
`ifdef DICE_RACE_OVERSHOOT_BOUNCE_EN
            dir_d    = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: ;
                WAIT_ROLL:
                    if (roll_req) state_d = WAIT_RESULT;
                WAIT_RESULT:
                    if (color_result_ready && movement_steps != 2'd0 &&
                        color_confidence >= MIN_CONFIDENCE) begin
                        steps_d = movement_steps;
                        color_d = detected_color;
                        cnt_d   = '0;
                        state_d = MOVE;
`ifdef DICE_RACE_OVERSHOOT_BOUNCE_EN
                        dir_d   = 1'b0;
`endif
                    end
                MOVE:
                    if (cnt == TC) begin
                        cnt_d   = '0;
                        tick_d  = 1'b1;
                        steps_d = steps_remaining - 2'd1;
`ifdef DICE_RACE_OVERSHOOT_BOUNCE_EN
                        // Once the finish cell is reached with steps left, walk back for the rest of the turn.
                        if (dir || active_pos == FINISH) begin
                            dir_d = 1'b1;
                            if (active_pos != '0) next_pos = active_pos - POS_W'(1);
                        end else begin
                            next_pos = active_pos + POS_W'(1);
                        end
                        if (steps_remaining == 2'd1) state_d = CHECK;
`else
                        if (active_pos != FINISH) next_pos = active_pos + POS_W'(1);
                        if (steps_remaining == 2'd1 || next_pos == FINISH) begin
                            steps_d = 2'd0;
                            state_d = CHECK;
                        end
`endif
                        if (current_player) p1_d = next_pos;
                        else                p0_d = next_pos;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                CHECK:
                    if (active_pos == FINISH) begin
                        over_d   = 1'b1;
                        winner_d = current_player;
                        state_d  = GAME_OVER;
                    end else begin
                        state_d  = SWITCH;
                    end
                SWITCH: begin
                    player_d = ~current_player;
                    state_d  = WAIT_ROLL;
                end
                GAME_OVER: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            current_player  <= 1'b0;
            p0_pos          <= '0;
            p1_pos          <= '0;
            steps_remaining <= 2'd0;
            last_color      <= 2'd0;
            step_tick       <= 1'b0;
            game_over       <= 1'b0;
            winner          <= 1'b0;
`ifdef DICE_RACE_OVERSHOOT_BOUNCE_EN
            dir             <= 1'b0;
`endif
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            current_player  <= player_d;
            p0_pos          <= p0_d;
            p1_pos          <= p1_d;
            steps_remaining <= steps_d;
            last_color      <= color_d;
            step_tick       <= tick_d;
            game_over       <= over_d;
            winner          <= winner_d;
`ifdef DICE_RACE_OVERSHOOT_BOUNCE_EN
            dir             <= dir_d;
`endif
        end
    end

endmodule
